decoder_2n_pipe: RTL and testbench

// - Registered binary-to-one-hot decoder, N -> 2**N, carrying a valid/ready stream in both directions.
// - Inverse of the 4-to-2 encoder path: a 2-bit code comes back as a 4-bit one-hot word.
// - Sits between a code producer (encoder or FSM) and one-hot consumers such as selects, enables and LED banks.
// - A 2-entry skid buffer gives full throughput with a registered in_ready.

---
 rtl/decoder_2n_pipe_pkg.sv | 32 +++
 rtl/decoder_2n_pipe_if.sv | 30 +++
 rtl/decoder_2n_pipe_skid.sv | 91 +++++++++
 rtl/decoder_2n_pipe.sv | 59 +++++
 tb/tb_decoder_2n_pipe.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/decoder_2n_pipe_pkg.sv
// Shared types and helpers for the registered N -> 2**N one-hot decoder.
// Holds the occupancy encoding used by the skid stage and the decode function.
package decoder_pkg;

    // Default code width and the matching one-hot width.
    localparam int N_DEF = 2;
    localparam int OUT_W = 2**N_DEF;

    // Widest code the decode helper handles; the block is legal up to N = 5.
    localparam int MAX_N = 5;
    localparam int MAX_W = 2**MAX_N;

    // Number of beats held by the 2-entry skid stage.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

    // One-hot image of a code. A disabled beat decodes to all zeros, so the
    // result never has more than one bit set.
    function automatic logic [MAX_W-1:0] onehot_of(input logic [MAX_N-1:0] code,
                                                   input logic             en);
        logic [MAX_W-1:0] r;
        r = '0;
        if (en) begin
            r[code] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/decoder_2n_pipe_if.sv
// Valid/ready bundle around the decoder: the code stream in, the one-hot
// stream out, and the delivered-beat counter.
// The master side is the producer/consumer environment; the slave side is the decoder.
interface decoder_2n_pipe_if #(
    parameter int N     = 2,
    parameter int CNT_W = 8
);
    localparam int OH_W = 2**N;

    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_code;
    logic             in_en;
    logic             out_valid;
    logic             out_ready;
    logic [OH_W-1:0]  out_onehot;
    logic [N-1:0]     out_code;
    logic [CNT_W-1:0] dec_count;

    modport master (
        output in_valid, in_code, in_en, out_ready,
        input  in_ready, out_valid, out_onehot, out_code, dec_count
    );

    modport slave (
        input  in_valid, in_code, in_en, out_ready,
        output in_ready, out_valid, out_onehot, out_code, dec_count
    );

endinterface

// File: rtl/decoder_2n_pipe_skid.sv
// Generic 2-entry valid/ready skid stage. The main register drives the output
// and the skid register catches the one beat that arrives while the output
// is stalled. This lets in_ready come straight from a flop without losing throughput.
import decoder_pkg::*;

module skid_buffer_2 #(
    parameter int W = OUT_W + N_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    occ_e         state;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic         accept;
    logic         deliver;

    // Handshake qualifiers; data is only ever sampled when accept is high.
    always_comb begin
        accept  = in_valid & in_ready;
        deliver = out_valid & out_ready;
    end

    // Occupancy FSM with registered in_ready/out_valid and the two data registers.
    // in_ready always equals "skid empty" in the next state. It is updated here
    // so that it is a flop and not a decode of the state.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the data registers are reset too, so out_* reads zero straight out of reset rather than stale or X content.
        if (!rst_n) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            main_q    <= '0;
            skid_q    <= '0;
        end else begin
            // NOTE: all sequential state uses non-blocking assignment, so every branch reads pre-edge values.
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        main_q    <= in_data;
                        out_valid <= 1'b1;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    unique case ({accept, deliver})
                        2'b11: begin
                            // Pass-through: the new beat replaces the one leaving, with no bubble.
                            main_q <= in_data;
                        end
                        2'b10: begin
                            // The output is stalled, so park the new beat and close the input.
                            skid_q   <= in_data;
                            in_ready <= 1'b0;
                            state    <= TWO;
                        end
                        2'b01: begin
                            out_valid <= 1'b0;
                            state     <= EMPTY;
                        end
                        default: begin
                        end
                    endcase
                end
                TWO: begin
                    if (deliver) begin
                        // The older parked beat moves up, which keeps FIFO order.
                        main_q   <= skid_q;
                        in_ready <= 1'b1;
                        state    <= ONE;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_data = main_q;

endmodule

// File: rtl/decoder_2n_pipe.sv
// Registered binary-to-one-hot decoder, N -> 2**N, with valid/ready on both sides.
// The decode is done at the accept edge and stored with the code in a 2-entry skid stage.
// A running count of delivered beats is kept beside it.
import decoder_pkg::*;

module decoder_2n_pipe #(
    parameter int N     = 2,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    decoder_2n_pipe_if.slave   bus
);

    localparam int W_OH = 2**N;
    localparam int W_D  = W_OH + N;

    logic [W_OH-1:0]  dec_onehot;
    logic [W_D-1:0]   in_data;
    logic [W_D-1:0]   out_data;
    logic             out_valid;
    logic [CNT_W-1:0] cnt;

    // Decode the incoming code. This is only captured on accept, so X on an
    // ignored input never reaches a register.
    always_comb begin
        // NOTE: every always_comb output gets a full assignment on every path, so no latch is inferred.
        dec_onehot = W_OH'(onehot_of(MAX_N'(bus.in_code), bus.in_en));
        in_data    = {dec_onehot, bus.in_code};
    end

    skid_buffer_2 #(
        .W (W_D)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (bus.out_ready),
        .out_data  (out_data)
    );

    // Delivered-beat counter. It includes disabled beats and wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (out_valid && bus.out_ready) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign bus.out_valid  = out_valid;
    assign bus.out_onehot = out_data[W_D-1:N];
    assign bus.out_code   = out_data[N-1:0];
    assign bus.dec_count  = cnt;

endmodule

// File: tb/tb_decoder_2n_pipe.sv
// Self-checking bench for decoder_2n_pipe. Instance A (N=2, CNT_W=8) carries
// the stream tests against a scoreboard queue. Instance B (CNT_W=2) shows counter wrap.
module tb_decoder_2n_pipe;

    typedef struct packed {
        logic [3:0] oh;
        logic [1:0] code;
    } beat_t;

    logic clk;
    logic rst_n;

    decoder_2n_pipe_if #(.N(2), .CNT_W(8)) ifa ();
    decoder_2n_pipe_if #(.N(2), .CNT_W(2)) ifb ();

    decoder_2n_pipe #(.N(2), .CNT_W(8)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa.slave)
    );

    decoder_2n_pipe #(.N(2), .CNT_W(2)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    beat_t      sb[$];
    logic [7:0] model_cnt;
    bit         stall_pend;
    beat_t      held;
    int         delivered;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t expect_of(input logic [1:0] code, input logic en);
        beat_t b;
        b.code = code;
        b.oh   = en ? (4'b0001 << code) : 4'b0000;
        return b;
    endfunction

    // One clock of instance A, starting and ending at a falling edge with the inputs already driven.
    task automatic tick(output bit acc);
        bit    dlv;
        beat_t e;
        check("dec_count", 32'(ifa.dec_count), 32'(model_cnt));
        if (stall_pend) begin
            check("stall_valid", 32'(ifa.out_valid), 32'd1);
            check("stall_hold", 32'({ifa.out_onehot, ifa.out_code}), 32'(held));
        end
        if (ifa.out_valid === 1'b1) begin
            check("onehot_bits", 32'($countones(ifa.out_onehot) <= 1), 32'd1);
        end
        acc = (ifa.in_valid === 1'b1) && (ifa.in_ready === 1'b1);
        dlv = (ifa.out_valid === 1'b1) && (ifa.out_ready === 1'b1);
        if (dlv) begin
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("out_onehot", 32'(ifa.out_onehot), 32'(e.oh));
                check("out_code", 32'(ifa.out_code), 32'(e.code));
            end
            delivered++;
        end
        if (acc) begin
            sb.push_back(expect_of(ifa.in_code, ifa.in_en));
        end
        stall_pend = (ifa.out_valid === 1'b1) && (ifa.out_ready !== 1'b1);
        held       = {ifa.out_onehot, ifa.out_code};
        @(posedge clk);
        if (dlv) model_cnt = model_cnt + 8'd1;
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [1:0] code, input logic en);
        ifa.in_valid = v;
        ifa.in_code  = code;
        ifa.in_en    = en;
    endtask

    logic [1:0] sweep_codes [4];
    logic [1:0] bp_codes    [3];
    bit         acc;
    int         budget;

    initial begin
        sweep_codes = '{2'b11, 2'b10, 2'b01, 2'b00};
        bp_codes    = '{2'b01, 2'b11, 2'b00};
        model_cnt   = '0;
        stall_pend  = 1'b0;
        delivered   = 0;
        rst_n       = 1'b0;
        drive(1'b0, 2'b00, 1'b0);
        ifa.out_ready = 1'b0;
        ifb.in_valid  = 1'b0;
        ifb.in_code   = 2'b00;
        ifb.in_en     = 1'b1;
        ifb.out_ready = 1'b0;

        // Reset values.
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(ifa.in_ready), 32'd1);
        check("rst_out_valid", 32'(ifa.out_valid), 32'd0);
        check("rst_out_onehot", 32'(ifa.out_onehot), 32'd0);
        check("rst_out_code", 32'(ifa.out_code), 32'd0);
        check("rst_dec_count", 32'(ifa.dec_count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Sweep 11,10,01,00 at full throughput; each beat is visible one cycle after accept.
        ifa.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, sweep_codes[i], 1'b1);
            tick(acc);
            check("sweep_acc", 32'(acc), 32'd1);
            check("sweep_valid", 32'(ifa.out_valid), 32'd1);
            check("sweep_onehot", 32'(ifa.out_onehot), 32'(4'b0001 << sweep_codes[i]));
        end
        drive(1'b0, 2'bxx, 1'bx);
        tick(acc);
        check("sweep_count", 32'(ifa.dec_count), 32'd4);

        // A disabled beat decodes to zero but is still echoed and counted.
        drive(1'b1, 2'b10, 1'b0);
        tick(acc);
        drive(1'b0, 2'bxx, 1'bx);
        check("dis_onehot", 32'(ifa.out_onehot), 32'd0);
        check("dis_code", 32'(ifa.out_code), 32'd2);
        tick(acc);
        check("dis_count", 32'(ifa.dec_count), 32'd5);

        // Backpressure: two beats fit, the third waits until the output drains.
        ifa.out_ready = 1'b0;
        drive(1'b1, bp_codes[0], 1'b1);
        tick(acc);
        check("bp_acc0", 32'(acc), 32'd1);
        drive(1'b1, bp_codes[1], 1'b1);
        tick(acc);
        check("bp_acc1", 32'(acc), 32'd1);
        check("bp_in_ready", 32'(ifa.in_ready), 32'd0);
        drive(1'b1, bp_codes[2], 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(acc);
            check("bp_blocked", 32'(acc), 32'd0);
            check("bp_hold", 32'(ifa.out_onehot), 32'b0010);
        end
        ifa.out_ready = 1'b1;
        budget = 0;
        while (sb.size() != 0 || ifa.in_valid === 1'b1) begin
            tick(acc);
            if (acc) drive(1'b0, 2'bxx, 1'bx);
            budget++;
            if (budget > 20) break;
        end
        check("bp_drain_in_time", 32'(budget <= 20), 32'd1);
        tick(acc);
        check("bp_count", 32'(ifa.dec_count), 32'd8);

        // Reset with two beats held discards both, asynchronously.
        ifa.out_ready = 1'b0;
        drive(1'b1, 2'b01, 1'b1);
        tick(acc);
        drive(1'b1, 2'b10, 1'b1);
        tick(acc);
        drive(1'b0, 2'bxx, 1'bx);
        check("pre_rst_valid", 32'(ifa.out_valid), 32'd1);
        check("pre_rst_ready", 32'(ifa.in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(ifa.out_valid), 32'd0);
        check("mid_rst_ready", 32'(ifa.in_ready), 32'd1);
        check("mid_rst_count", 32'(ifa.dec_count), 32'd0);
        check("mid_rst_onehot", 32'(ifa.out_onehot), 32'd0);
        sb.delete();
        stall_pend = 1'b0;
        model_cnt  = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Random traffic. Ignored inputs are driven to X.
        delivered = 0;
        budget    = 0;
        while (delivered < 1000 && budget < 6000) begin
            ifa.out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) != 0) begin
                drive(1'b1, 2'($urandom_range(0, 3)), ($urandom_range(0, 5) != 0));
            end else begin
                drive(1'b0, 2'bxx, 1'bx);
            end
            tick(acc);
            budget++;
        end
        check("rand_in_time", 32'(delivered >= 1000), 32'd1);
        drive(1'b0, 2'bxx, 1'bx);
        ifa.out_ready = 1'b1;
        budget = 0;
        while (sb.size() != 0 && budget < 10) begin
            tick(acc);
            budget++;
        end
        check("rand_drained", 32'(sb.size()), 32'd0);

        // Counter wrap on the 2-bit instance: 1,2,3,0,1.
        ifb.out_ready = 1'b1;
        ifb.in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            if (i == 4) ifb.in_valid = 1'b0;
            ifb.in_code = 2'(i);
            @(posedge clk);
            @(negedge clk);
            check("wrap_count", 32'(ifb.dec_count), 32'((i + 1) % 4));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
